// File: rtl/irda_mir_bit_destuffer.sv
// MIR receive bit de-stuffer: removes HDLC stuffed zeros, detects flags and
// aborts, and releases frame data bits through a 7-bit delay line so that the
// closing flag's own bits can be discarded before they reach the output.
module irda_mir_bit_destuffer #(
  parameter int unsigned DEPTH = 7
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic bds_restart,
  input  logic mir_rxbit_enable,
  input  logic destuffer_i,
  output logic destuffer_o,
  output logic data_valid_o,
  output logic flag_o,
  output logic abort_o,
  output logic in_frame_o
);

  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0] CNT_STUFF = CNT_W'(5);
  localparam logic [CNT_W-1:0] CNT_FLAG  = CNT_W'(6);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(7);

  // Registered state
  logic [CNT_W-1:0] r_ones_cnt;
  logic [DEPTH-1:0] r_dl_bit;
  logic [DEPTH-1:0] r_dl_vld;
  logic             r_dout;
  logic             r_data_valid;
  logic             r_flag;
  logic             r_abort;
  logic             r_in_frame;

  // Next-state values
  logic [CNT_W-1:0] w_ones_cnt;
  logic [DEPTH-1:0] w_dl_bit;
  logic [DEPTH-1:0] w_dl_vld;
  logic             w_dout;
  logic             w_data_valid;
  logic             w_flag;
  logic             w_abort;
  logic             w_in_frame;
  logic             w_candidate;

  // Classify the incoming bit against the run of 1s and compute next state
  always_comb begin
    w_ones_cnt   = r_ones_cnt;
    w_dl_bit     = r_dl_bit;
    w_dl_vld     = r_dl_vld;
    w_dout       = r_dout;
    w_data_valid = 1'b0;
    w_flag       = 1'b0;
    w_abort      = 1'b0;
    w_in_frame   = r_in_frame;
    w_candidate  = 1'b0;

    if (mir_rxbit_enable) begin
      if (destuffer_i) begin
        if (r_ones_cnt == CNT_FLAG) begin
          // seventh 1: abort, drop everything in flight
          w_abort    = 1'b1;
          w_in_frame = 1'b0;
          w_dl_vld   = '0;
          w_ones_cnt = CNT_SAT;
        end else if (r_ones_cnt == CNT_SAT) begin
          // still inside the abort run: nothing to do
          w_ones_cnt = CNT_SAT;
        end else begin
          w_ones_cnt  = r_ones_cnt + CNT_W'(1);
          w_candidate = 1'b1;
        end
      end else begin
        if (r_ones_cnt == CNT_STUFF) begin
          // stuffed zero: dropped without shifting
          w_ones_cnt = '0;
        end else if (r_ones_cnt == CNT_FLAG) begin
          // flag closes: its first seven bits sit in the delay line, discard them
          w_flag     = 1'b1;
          w_in_frame = 1'b1;
          w_dl_vld   = '0;
          w_ones_cnt = '0;
        end else begin
          w_ones_cnt  = '0;
          w_candidate = 1'b1;
        end
      end

      if (w_candidate && r_in_frame) begin
        w_dout       = r_dl_bit[DEPTH-1];
        w_data_valid = r_dl_vld[DEPTH-1];
        w_dl_bit     = {r_dl_bit[DEPTH-2:0], destuffer_i};
        w_dl_vld     = {r_dl_vld[DEPTH-2:0], 1'b1};
      end
    end
  end

  // State register with synchronous reset / soft restart
  always_ff @(posedge clk) begin
    if (wb_rst_i || bds_restart) begin
      r_ones_cnt   <= '0;
      r_dl_bit     <= '0;
      r_dl_vld     <= '0;
      r_dout       <= 1'b0;
      r_data_valid <= 1'b0;
      r_flag       <= 1'b0;
      r_abort      <= 1'b0;
      r_in_frame   <= 1'b0;
    end else begin
      r_ones_cnt   <= w_ones_cnt;
      r_dl_bit     <= w_dl_bit;
      r_dl_vld     <= w_dl_vld;
      r_dout       <= w_dout;
      r_data_valid <= w_data_valid;
      r_flag       <= w_flag;
      r_abort      <= w_abort;
      r_in_frame   <= w_in_frame;
    end
  end

  assign destuffer_o  = r_dout;
  assign data_valid_o = r_data_valid;
  assign flag_o       = r_flag;
  assign abort_o      = r_abort;
  assign in_frame_o   = r_in_frame;

endmodule

// File: tb/tb_irda_mir_bit_destuffer.sv
// Self-checking bench for irda_mir_bit_destuffer: directed scenarios plus
// randomized frames and raw bit streams against a queue-based reference model.
module tb_irda_mir_bit_destuffer;

  logic clk;
  logic wb_rst_i;
  logic bds_restart;
  logic mir_rxbit_enable;
  logic destuffer_i;
  logic destuffer_o;
  logic data_valid_o;
  logic flag_o;
  logic abort_o;
  logic in_frame_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int   m_ones;
  bit   m_inframe;
  logic m_q[$];

  // Per-scenario observations
  logic got_q[$];
  int   flag_pos[$];
  int   abort_pos[$];
  int   bit_idx;
  int   gap_max;

  irda_mir_bit_destuffer #(.DEPTH(7)) dut (
    .clk              (clk),
    .wb_rst_i         (wb_rst_i),
    .bds_restart      (bds_restart),
    .mir_rxbit_enable (mir_rxbit_enable),
    .destuffer_i      (destuffer_i),
    .destuffer_o      (destuffer_o),
    .data_valid_o     (data_valid_o),
    .flag_o           (flag_o),
    .abort_o          (abort_o),
    .in_frame_o       (in_frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_ones    = 0;
    m_inframe = 1'b0;
    m_q.delete();
  endtask

  task automatic scen_clear();
    got_q.delete();
    flag_pos.delete();
    abort_pos.delete();
    bit_idx = 0;
  endtask

  // Send one enabled bit, predict and check the edge, then idle a random gap
  task automatic send_bit(input logic b);
    logic e_v, e_f, e_a, e_b;
    bit   cand;
    int   gap;
    e_v = 1'b0; e_f = 1'b0; e_a = 1'b0; e_b = 1'b0; cand = 1'b0;
    if (b) begin
      if (m_ones == 6) begin
        e_a = 1'b1; m_inframe = 1'b0; m_q.delete(); m_ones = 7;
      end else if (m_ones < 6) begin
        m_ones++; cand = 1'b1;
      end
    end else begin
      if (m_ones == 5) m_ones = 0;
      else if (m_ones == 6) begin
        e_f = 1'b1; m_inframe = 1'b1; m_q.delete(); m_ones = 0;
      end else begin
        m_ones = 0; cand = 1'b1;
      end
    end
    if (cand && m_inframe) begin
      m_q.push_back(b);
      if (m_q.size() > 7) begin
        e_b = m_q.pop_front();
        e_v = 1'b1;
      end
    end

    mir_rxbit_enable = 1'b1;
    destuffer_i      = b;
    @(posedge clk); #1;
    mir_rxbit_enable = 1'b0;
    destuffer_i      = 1'($urandom_range(0, 1));
    bit_idx++;

    checks++;
    if (data_valid_o !== e_v) begin
      failures++; $display("FAIL data_valid bit%0d got=%b exp=%b", bit_idx, data_valid_o, e_v);
    end
    if (e_v) begin
      checks++;
      if (destuffer_o !== e_b) begin
        failures++; $display("FAIL destuffer_o bit%0d got=%b exp=%b", bit_idx, destuffer_o, e_b);
      end
    end
    checks++;
    if (flag_o !== e_f) begin
      failures++; $display("FAIL flag bit%0d got=%b exp=%b", bit_idx, flag_o, e_f);
    end
    checks++;
    if (abort_o !== e_a) begin
      failures++; $display("FAIL abort bit%0d got=%b exp=%b", bit_idx, abort_o, e_a);
    end
    checks++;
    if (in_frame_o !== m_inframe) begin
      failures++; $display("FAIL in_frame bit%0d got=%b exp=%b", bit_idx, in_frame_o, m_inframe);
    end

    if (data_valid_o === 1'b1) got_q.push_back(destuffer_o);
    if (flag_o === 1'b1) flag_pos.push_back(bit_idx);
    if (abort_o === 1'b1) abort_pos.push_back(bit_idx);

    gap = $urandom_range(0, gap_max);
    repeat (gap) begin
      @(posedge clk); #1;
      checks++;
      if ({data_valid_o, flag_o, abort_o} !== 3'b000 || in_frame_o !== m_inframe) begin
        failures++;
        $display("FAIL idle_gap bit%0d got v/f/a/inf=%b%b%b%b exp=000%b",
                 bit_idx, data_valid_o, flag_o, abort_o, in_frame_o, m_inframe);
      end
    end
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
  endtask

  // Transmit-side stuffing: insert 0 after five consecutive 1s
  task automatic send_data(input logic d[$]);
    int run;
    run = 0;
    foreach (d[i]) begin
      send_bit(d[i]);
      if (d[i]) begin
        run++;
        if (run == 5) begin send_bit(1'b0); run = 0; end
      end else run = 0;
    end
  endtask

  task automatic check_bits(input string name, input logic exp[$]);
    bit ok;
    checks++;
    ok = (got_q.size() == exp.size());
    if (ok) foreach (exp[i]) if (got_q[i] !== exp[i]) ok = 1'b0;
    if (!ok) begin
      failures++;
      $display("FAIL %s got_n=%0d exp_n=%0d got_first=%b exp_first=%b", name,
               got_q.size(), exp.size(),
               (got_q.size() > 0) ? got_q[0] : 1'bx, (exp.size() > 0) ? exp[0] : 1'bx);
    end
  endtask

  task automatic do_restart();
    bds_restart = 1'b1;
    @(posedge clk); #1;
    bds_restart = 1'b0;
    model_clear();
    checks++;
    if ({destuffer_o, data_valid_o, flag_o, abort_o, in_frame_o} !== 5'b00000) begin
      failures++;
      $display("FAIL restart_outputs got=%b%b%b%b%b exp=00000",
               destuffer_o, data_valid_o, flag_o, abort_o, in_frame_o);
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; bds_restart = 1'b0; mir_rxbit_enable = 1'b0; destuffer_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({destuffer_o, data_valid_o, flag_o, abort_o, in_frame_o} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b%b exp=00000",
               destuffer_o, data_valid_o, flag_o, abort_o, in_frame_o);
    end
    wb_rst_i = 1'b0;
    model_clear();
  endtask

  task automatic test_idle_ones();
    scen_clear(); gap_max = 0;
    repeat (24) send_bit(1'b1);
    checks++;
    if (abort_pos.size() != 1 || abort_pos[0] != 7) begin
      failures++; $display("FAIL idle_abort got_n=%0d exp_n=1 at bit 7", abort_pos.size());
    end
    checks++;
    if (got_q.size() != 0 || in_frame_o !== 1'b0) begin
      failures++; $display("FAIL idle_state got_valid=%0d inf=%b exp 0/0", got_q.size(), in_frame_o);
    end
  endtask

  task automatic frame_a5(input string name, input int gmax);
    logic d[$];
    logic exp[$];
    d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp = d;
    scen_clear(); gap_max = gmax;
    send_flag();
    send_data(d);
    send_flag();
    check_bits(name, exp);
    checks++;
    if (flag_pos.size() != 2 || flag_pos[0] != 8 || flag_pos[1] != 24) begin
      failures++;
      $display("FAIL %s_flags got_n=%0d first=%0d exp 2 at 8,24", name, flag_pos.size(),
               (flag_pos.size() > 0) ? flag_pos[0] : -1);
    end
    checks++;
    if (in_frame_o !== 1'b1) begin
      failures++; $display("FAIL %s_inframe got=%b exp=1", name, in_frame_o);
    end
  endtask

  task automatic test_stuffed_zero();
    logic d[$];
    logic exp[$];
    d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp = d;
    scen_clear(); gap_max = 1;
    send_flag();
    send_data(d);
    send_flag();
    check_bits("stuffed_data", exp);
    checks++;
    if (abort_pos.size() != 0 || flag_pos.size() != 2) begin
      failures++; $display("FAIL stuffed_events aborts=%0d flags=%0d exp 0/2", abort_pos.size(), flag_pos.size());
    end
  endtask

  task automatic test_abort();
    logic d[$];
    logic exp[$];
    int   abort_bit;
    for (int i = 0; i < 10; i++) d.push_back(1'($urandom_range(0, 1)));
    d[9] = 1'b0;
    for (int i = 0; i < 9; i++) exp.push_back(d[i]);
    scen_clear(); gap_max = 0;
    send_flag();
    send_data(d);
    repeat (7) send_bit(1'b1);
    abort_bit = bit_idx;
    check_bits("abort_data", exp);
    checks++;
    if (abort_pos.size() != 1 || abort_pos[0] != abort_bit || in_frame_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_event n=%0d at=%0d exp at=%0d inf=%b", abort_pos.size(),
               (abort_pos.size() > 0) ? abort_pos[0] : -1, abort_bit, in_frame_o);
    end
    send_flag();
    checks++;
    if (in_frame_o !== 1'b1 || flag_pos.size() != 2) begin
      failures++; $display("FAIL abort_reopen inf=%b flags=%0d exp 1/2", in_frame_o, flag_pos.size());
    end
  endtask

  task automatic test_restart();
    logic d[$];
    d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    scen_clear(); gap_max = 0;
    send_flag();
    send_data(d);
    checks++;
    if (destuffer_o !== 1'b1 || in_frame_o !== 1'b1) begin
      failures++; $display("FAIL restart_pre dout=%b inf=%b exp 1/1", destuffer_o, in_frame_o);
    end
    do_restart();
    scen_clear();
    send_flag();
    checks++;
    if (flag_pos.size() != 1 || flag_pos[0] != 8 || in_frame_o !== 1'b1) begin
      failures++; $display("FAIL restart_reflag flags=%0d inf=%b exp 1/1", flag_pos.size(), in_frame_o);
    end
  endtask

  task automatic test_back_to_back();
    scen_clear(); gap_max = 0;
    send_flag();
    send_flag();
    checks++;
    if (flag_pos.size() != 2 || got_q.size() != 0) begin
      failures++; $display("FAIL b2b flags=%0d valid=%0d exp 2/0", flag_pos.size(), got_q.size());
    end
  endtask

  task automatic test_random_frames();
    logic exp[$];
    logic d[$];
    int   n;
    scen_clear(); gap_max = 3;
    send_flag();
    for (int f = 0; f < 20; f++) begin
      d.delete();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        d.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        exp.push_back(d[i]);
      end
      send_data(d);
      send_flag();
    end
    check_bits("random_frames", exp);
    checks++;
    if (abort_pos.size() != 0 || flag_pos.size() != 21) begin
      failures++; $display("FAIL random_frames_events aborts=%0d flags=%0d exp 0/21", abort_pos.size(), flag_pos.size());
    end
  endtask

  task automatic test_random_raw();
    scen_clear(); gap_max = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_restart();
      send_bit(($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    gap_max = 0;
    model_clear();
    scen_clear();
    test_reset();
    test_idle_ones();
    frame_a5("frame_a5", 0);
    test_stuffed_zero();
    test_abort();
    test_restart();
    frame_a5("gaps_a5", 5);
    test_back_to_back();
    test_random_frames();
    test_random_raw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
